alu_op_sequencer: RTL and testbench

Initiator side of the ALU operand/select interface. It collects two operands and an operation code from board switches, one debounced key press per step. It drives them onto the ALU's data_1/data_2/sel inputs and captures the ALU's alu_out/alu_zero_flag into held result registers for display. It sits in mipscpu beside the ALU and the clock divider, and replaces direct pin drive of the ALU inputs.

---
 rtl/alu_op_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Collects operand A, operand B and an ALU select from switches
//            (one debounced key press per step), drives the ALU and holds the
//            returned result and zero flag for display.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
    parameter int WORD_SIZE       = 8,
    parameter int OP_SIZE         = 3,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 key_ok,
    input  logic [WORD_SIZE-1:0] sw,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_zero_flag,
    output logic [WORD_SIZE-1:0] data_1,
    output logic [WORD_SIZE-1:0] data_2,
    output logic [OP_SIZE-1:0]   sel,
    output logic [WORD_SIZE-1:0] result,
    output logic                 result_zero,
    output logic                 done,
    output logic [3:0]           step
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 key_meta_q, key_meta_d;
    logic                 key_s_q, key_s_d;
    logic [1:0]           fill_q, fill_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 stable_q, stable_d;
    logic                 stable_dly_q, stable_dly_d;
    logic                 armed_q, armed_d;
    logic                 key_evt_q, key_evt_d;
    logic [WORD_SIZE-1:0] data_1_q, data_1_d;
    logic [WORD_SIZE-1:0] data_2_q, data_2_d;
    logic [OP_SIZE-1:0]   sel_q, sel_d;
    logic [WORD_SIZE-1:0] result_q, result_d;
    logic                 result_zero_q, result_zero_d;
    logic                 done_q, done_d;

    always_comb begin
        key_meta_d    = key_ok;
        key_s_d       = key_meta_q;
        fill_d        = {fill_q[0], 1'b1};
        cnt_d         = '0;
        stable_d      = stable_q;
        stable_dly_d  = stable_q;
        armed_d       = armed_q;
        key_evt_d     = 1'b0;
        state_d       = state_q;
        data_1_d      = data_1_q;
        data_2_d      = data_2_q;
        sel_d         = sel_q;
        result_d      = result_q;
        result_zero_d = result_zero_q;
        done_d        = 1'b0;

        if (key_s_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = key_s_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A key held through reset must be seen released before it can fire.
        armed_d   = armed_q | (fill_q[1] & ~key_s_q);
        key_evt_d = stable_q & ~stable_dly_q & armed_q;

        case (state_q)
            S_LOAD_A: begin
                if (key_evt_q) begin
                    data_1_d = sw;
                    state_d  = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (key_evt_q) begin
                    data_2_d = sw;
                    state_d  = S_LOAD_OP;
                end
            end
            S_LOAD_OP: begin
                if (key_evt_q) begin
                    sel_d   = sw[OP_SIZE-1:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d      = alu_out;
                result_zero_d = alu_zero_flag;
                done_d        = 1'b1;
                state_d       = S_SHOW;
            end
            S_SHOW: begin
                if (key_evt_q) begin
                    state_d = S_LOAD_A;
                end
            end
            default: begin
                state_d = S_LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_meta_q    <= 1'b0;
            key_s_q       <= 1'b0;
            fill_q        <= 2'b00;
            cnt_q         <= '0;
            stable_q      <= 1'b0;
            stable_dly_q  <= 1'b0;
            armed_q       <= 1'b0;
            key_evt_q     <= 1'b0;
            state_q       <= S_LOAD_A;
            data_1_q      <= '0;
            data_2_q      <= '0;
            sel_q         <= '0;
            result_q      <= '0;
            result_zero_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            key_meta_q    <= key_meta_d;
            key_s_q       <= key_s_d;
            fill_q        <= fill_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_dly_q  <= stable_dly_d;
            armed_q       <= armed_d;
            key_evt_q     <= key_evt_d;
            state_q       <= state_d;
            data_1_q      <= data_1_d;
            data_2_q      <= data_2_d;
            sel_q         <= sel_d;
            result_q      <= result_d;
            result_zero_q <= result_zero_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        step = 4'b0000;
        case (state_q)
            S_LOAD_A:  step = 4'b0001;
            S_LOAD_B:  step = 4'b0010;
            S_LOAD_OP: step = 4'b0100;
            S_SHOW:    step = 4'b1000;
            default:   step = 4'b0000;
        endcase
    end

    assign data_1      = data_1_q;
    assign data_2      = data_2_q;
    assign sel         = sel_q;
    assign result      = result_q;
    assign result_zero = result_zero_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Self-checking bench for alu_op_sequencer with a reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       key_ok;
    logic [7:0] sw;
    logic [7:0] alu_out;
    logic       alu_z;
    logic [7:0] data_1, data_2, result;
    logic [2:0] sel;
    logic       result_zero, done;
    logic [3:0] step;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    bit cmp_en   = 1'b0;

    alu_op_sequencer #(.WORD_SIZE(8), .OP_SIZE(3), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rstn(rstn), .key_ok(key_ok), .sw(sw),
        .alu_out(alu_out), .alu_zero_flag(alu_z),
        .data_1(data_1), .data_2(data_2), .sel(sel),
        .result(result), .result_zero(result_zero), .done(done), .step(step)
    );

    always #5 clk = ~clk;

    // Reference model: raw key history, debounced level, sequencing by step.
    logic [63:0] m_hist;
    logic        m_stable, m_pend, m_evt, m_armed, m_done, m_rz;
    int          m_edges, m_state;
    logic [7:0]  m_d1, m_d2, m_res;
    logic [2:0]  m_sel;

    function automatic logic window_flips(logic [63:0] h, logic st);
        for (int i = 1; i <= D; i++)
            if (h[i] == st) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] step_of(int s);
        case (s)
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            3: return 4'b0000;
            default: return 4'b1000;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_hist <= '0; m_stable <= 1'b0; m_pend <= 1'b0; m_evt <= 1'b0;
            m_armed <= 1'b0; m_edges <= 0; m_state <= 0; m_done <= 1'b0;
            m_d1 <= '0; m_d2 <= '0; m_sel <= '0; m_res <= '0; m_rz <= 1'b0;
        end else begin
            m_hist  <= {m_hist[62:0], key_ok};
            m_edges <= m_edges + 1;
            if (m_edges >= 2 && !m_hist[1]) m_armed <= 1'b1;
            if (window_flips(m_hist, m_stable)) m_stable <= ~m_stable;
            m_pend  <= window_flips(m_hist, m_stable) && !m_stable;
            m_evt   <= m_pend && m_armed;
            m_done  <= (m_state == 3);
            case (m_state)
                0: if (m_evt) begin m_d1 <= sw; m_state <= 1; end
                1: if (m_evt) begin m_d2 <= sw; m_state <= 2; end
                2: if (m_evt) begin m_sel <= sw[2:0]; m_state <= 3; end
                3: begin m_res <= alu_out; m_rz <= alu_z; m_state <= 4; end
                default: if (m_evt) m_state <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (cmp_en) begin
            chk("m_data_1", data_1, m_d1);
            chk("m_data_2", data_2, m_d2);
            chk("m_sel", sel, m_sel);
            chk("m_result", result, m_res);
            chk("m_result_zero", result_zero, m_rz);
            chk("m_done", done, m_done);
            chk("m_step", step, step_of(m_state));
        end
    end

    // Raise key at a falling edge, hold, release; lat = falling edges until step moves.
    task automatic press(input int hold, output int lat);
        logic [3:0] s0;
        s0  = step;
        lat = -1;
        key_ok = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (lat < 0 && step != s0) lat = k;
        end
        key_ok = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (lat < 0 && step != s0) lat = hold + k;
        end
    endtask

    int lat;
    int dc0;

    initial begin
        rstn = 1'b0; key_ok = 1'b0; sw = 8'h00; alu_out = 8'h00; alu_z = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_step", step, 4'b0001);
        chk("reset_data_1", data_1, 0);
        chk("reset_result", result, 0);
        chk("reset_done", done, 0);
        cmp_en = 1'b1;
        rstn   = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_stays_load_a", step, 4'b0001);

        // Full add sequence
        alu_out = 8'h34; alu_z = 1'b0;
        dc0 = done_cnt;
        sw = 8'h23; press(10, lat);
        sw = 8'h11; press(10, lat);
        sw = 8'h00; press(10, lat);
        chk("add_data_1", data_1, 8'h23);
        chk("add_data_2", data_2, 8'h11);
        chk("add_sel", sel, 0);
        chk("add_result", result, 8'h34);
        chk("add_zero", result_zero, 0);
        chk("add_step", step, 4'b1000);
        chk("add_done_pulses", done_cnt - dc0, 1);
        press(10, lat);
        chk("back_to_load_a", step, 4'b0001);

        // Zero capture with upper switch bits set on the select step
        alu_out = 8'h00; alu_z = 1'b1;
        sw = 8'h05; press(10, lat);
        press(10, lat);
        sw = 8'hF9; press(10, lat);
        chk("sub_sel_low_bits", sel, 3'd1);
        chk("sub_result", result, 8'h00);
        chk("sub_zero", result_zero, 1);
        alu_out = 8'h99; alu_z = 1'b0;
        press(10, lat);
        chk("zero_retained_step", step, 4'b0001);
        chk("zero_retained_result", result, 8'h00);
        chk("zero_retained_flag", result_zero, 1);

        // Short bounces never advance
        for (int p = 0; p < 5; p++) begin
            key_ok = 1'b1; repeat (3) @(negedge clk);
            key_ok = 1'b0; repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("bounce_no_advance", step, 4'b0001);

        // Long press: exactly one advance, event D+3 edges after the rise
        sw = 8'h42; press(50, lat);
        chk("long_press_step", step, 4'b0010);
        chk("long_press_latency", lat, D + 4);
        chk("long_press_data_1", data_1, 8'h42);

        // Walk back to LOAD_A, then hold the key for 200 cycles
        alu_out = 8'h77;
        sw = 8'h3C; press(10, lat);
        press(10, lat);
        press(10, lat);
        chk("pre_hold_step", step, 4'b0001);
        sw = 8'h5A; key_ok = 1'b1;
        repeat (20) @(negedge clk);
        sw = 8'hFF;
        repeat (180) @(negedge clk);
        key_ok = 1'b0;
        repeat (12) @(negedge clk);
        chk("hold_step", step, 4'b0010);
        chk("hold_data_1", data_1, 8'h5A);
        chk("hold_data_2", data_2, 8'h3C);

        // Reach LOAD_OP with data_1 = AA, then reset between clock edges
        press(10, lat);
        press(10, lat);
        press(10, lat);
        sw = 8'hAA; press(10, lat);
        sw = 8'h01; press(10, lat);
        chk("pre_reset_step", step, 4'b0100);
        chk("pre_reset_data_1", data_1, 8'hAA);
        chk("pre_reset_result", result, 8'h77);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_step", step, 4'b0001);
        chk("async_reset_data_1", data_1, 0);
        chk("async_reset_result", result, 0);
        chk("async_reset_data_2", data_2, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_idle", step, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
